// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction layout,
// opcode constants, sizing and state encoding.
package inst_sequencer_pkg;

  localparam int INST_WIDTH = 28;
  localparam int PROG_AW    = 8;
  localparam int ADDR_W     = 4 + PROG_AW;
  localparam int CNT_W      = PROG_AW + 1;

  // Instruction fields: {opcode[27:25], payload[24:0]}
  localparam int OP_MSB = 27;
  localparam int OP_LSB = 25;

  typedef logic [OP_MSB-OP_LSB:0] opcode_t;

  // Terminates a program; never handed downstream.
  localparam opcode_t END_OP = 3'b111;

  // State encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_ISSUE = ST_ISSUE,
    S_DONE  = ST_DONE
  } state_e;

  function automatic logic is_end(input logic [INST_WIDTH-1:0] word);
    return word[OP_MSB:OP_LSB] == END_OP;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Program-ROM read port plus downstream instruction valid/ready stream.
interface inst_sequencer_if;
  import inst_sequencer_pkg::*;

  logic                  rom_en;
  logic [ADDR_W-1:0]     rom_addr;
  logic [INST_WIDTH-1:0] rom_data;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  inst_ready;

  // Sequencer side
  modport master (
    output rom_en, rom_addr, inst, inst_valid,
    input  rom_data, inst_ready
  );

  // ROM / downstream side
  modport slave (
    input  rom_en, rom_addr, inst, inst_valid,
    output rom_data, inst_ready
  );

endinterface

// File: rtl/inst_sequencer.sv
// Microprogram sequencer: fetches instructions of the program selected by
// {level, mode_ctrl} from a sync-read ROM and issues them downstream over
// valid/ready until the END opcode, with abort, overflow error and count.
module inst_sequencer
  import inst_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        level,
  input  logic [1:0]        mode_ctrl,
  inst_sequencer_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  inst_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << PROG_AW);

  state_e                state_q;
  logic [PROG_AW-1:0]    pc_q;
  logic [PROG_AW-1:0]    pc_d;
  logic [1:0]            level_q;
  logic [1:0]            mode_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  inst_valid_q;
  logic                  rom_en_q;
  logic [ADDR_W-1:0]     rom_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  pc_last;

  // Next pc, saturating handoff count and last-slot detection
  always_comb begin
    pc_d    = pc_q + 1'b1;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    pc_last = &pc_q;
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      level_q      <= '0;
      mode_q       <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // rom_en and done are single-cycle strobes
      rom_en_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort) begin
        // Abort beats every transition; count, pc and error are kept
        state_q      <= S_IDLE;
        inst_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              level_q    <= level;
              mode_q     <= mode_ctrl;
              pc_q       <= '0;
              cnt_q      <= '0;
              error_q    <= 1'b0;
              rom_en_q   <= 1'b1;
              rom_addr_q <= {level, mode_ctrl, {PROG_AW{1'b0}}};
              busy_q     <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
          S_FETCH: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            inst_q <= bus.rom_data;
            if (is_end(bus.rom_data)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              inst_valid_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (bus.inst_ready) begin
              inst_valid_q <= 1'b0;
              cnt_q        <= cnt_d;
              if (pc_last) begin
                // Ran off the end of the program slot without END
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                pc_q       <= pc_d;
                rom_en_q   <= 1'b1;
                rom_addr_q <= {level_q, mode_q, pc_d};
                state_q    <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign inst_cnt       = cnt_q;

endmodule
